// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM datapath: control-field enums,
// the R15 index and ALU flag bit positions.
package arm_mc_pkg;

  typedef enum logic [1:0] {
    SrcAReg    = 2'b00,
    SrcAAluOut = 2'b01,
    SrcAPc     = 2'b10
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SrcBReg  = 2'b00,
    SrcBImm  = 2'b01,
    SrcBFour = 2'b10
  } alu_src_b_e;

  typedef enum logic [1:0] {
    ResAluOut    = 2'b00,
    ResData      = 2'b01,
    ResAluResult = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    ImmZe8    = 2'b00,
    ImmZe12   = 2'b01,
    ImmBranch = 2'b10,
    ImmZero   = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    AluAdd = 2'b00,
    AluSub = 2'b01,
    AluAnd = 2'b10,
    AluOrr = 2'b11
  } alu_ctrl_e;

  localparam logic [3:0] PC_IDX = 4'd15;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/arm_mc_datapath_if.sv
// Controller/memory-facing bus of the multicycle datapath. The master side
// drives control and read data; the slave (datapath) returns address, data and status.
interface arm_mc_datapath_if;
  logic        PCWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  ALUControl;
  logic [31:0] ReadData;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic        MemWE;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;

  modport master (
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, ALUControl, ReadData,
    input  Adr, WriteData, MemWE, Instr, ALUFlags
  );

  modport slave (
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, ALUControl, ReadData,
    output Adr, WriteData, MemWE, Instr, ALUFlags
  );
endinterface

// File: rtl/arm_mc_regfile.sv
// R0-R14 with two combinational reads and one synchronous write; index 15 reads
// the r15 input. ARM_MC_DATAPATH_DBG_PORT_EN adds a third read port (15 -> PC).
module arm_mc_regfile
  import arm_mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  wa,
  input  logic [31:0] wd,
  input  logic [3:0]  ra1,
  input  logic [3:0]  ra2,
  input  logic [31:0] r15,
  output logic [31:0] rd1,
  output logic [31:0] rd2
`ifdef ARM_MC_DATAPATH_DBG_PORT_EN
  ,
  input  logic [3:0]  dbg_ra,
  input  logic [31:0] dbg_pc,
  output logic [31:0] dbg_rd
`endif
);

  logic [31:0] regs_q [15];

  // R15 has no storage; writes to it are dropped here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (wa != PC_IDX)) begin
      regs_q[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == PC_IDX) ? r15 : regs_q[ra1];
  assign rd2 = (ra2 == PC_IDX) ? r15 : regs_q[ra2];

`ifdef ARM_MC_DATAPATH_DBG_PORT_EN
  assign dbg_rd = (dbg_ra == PC_IDX) ? dbg_pc : regs_q[dbg_ra];
`endif

endmodule

// File: rtl/arm_mc_datapath.sv
// Multicycle ARM datapath: PC/IR/Data/A/B/ALUOut, register file, extender and ALU.
// Optional debug read port enabled by ARM_MC_DATAPATH_DBG_PORT_EN.
module arm_mc_datapath
  import arm_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  arm_mc_datapath_if.slave   bus
`ifdef ARM_MC_DATAPATH_DBG_PORT_EN
  ,
  input  logic [3:0]         DbgRA,
  output logic [31:0]        DbgRD
`endif
);

  logic [31:0] pc_q, ir_q, data_q, a_q, b_q, alu_out_q;
  logic [31:0] rd1, rd2, ext_imm, src_a, src_b, b_op, alu_result, result;
  logic [32:0] sum;
  logic [3:0]  ra1, ra2;
  logic        is_sub, carry, ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      data_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
    end else begin
      if (bus.PCWrite) pc_q <= result;
      if (bus.IRWrite) ir_q <= bus.ReadData;
      data_q    <= bus.ReadData;
      a_q       <= rd1;
      b_q       <= rd2;
      alu_out_q <= alu_result;
    end
  end

  assign ra1 = bus.RegSrc[0] ? PC_IDX : ir_q[19:16];
  assign ra2 = bus.RegSrc[1] ? ir_q[15:12] : ir_q[3:0];

  arm_mc_regfile u_regfile (
    .clk    (clk),
    .rst    (reset),
    .we     (bus.RegWrite),
    .wa     (ir_q[15:12]),
    .wd     (result),
    .ra1    (ra1),
    .ra2    (ra2),
    .r15    (result),
    .rd1    (rd1),
    .rd2    (rd2)
`ifdef ARM_MC_DATAPATH_DBG_PORT_EN
    ,
    .dbg_ra (DbgRA),
    .dbg_pc (pc_q),
    .dbg_rd (DbgRD)
`endif
  );

  always_comb begin
    ext_imm = '0;
    unique case (imm_src_e'(bus.ImmSrc))
      ImmZe8:    ext_imm = {24'd0, ir_q[7:0]};
      ImmZe12:   ext_imm = {20'd0, ir_q[11:0]};
      ImmBranch: ext_imm = {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
      ImmZero:   ext_imm = '0;
    endcase
  end

  always_comb begin
    src_a = a_q;
    case (alu_src_a_e'(bus.ALUSrcA))
      SrcAAluOut: src_a = alu_out_q;
      SrcAPc:     src_a = pc_q;
      default:    src_a = a_q;
    endcase

    src_b = 32'd4;
    case (alu_src_b_e'(bus.ALUSrcB))
      SrcBReg: src_b = b_q;
      SrcBImm: src_b = ext_imm;
      default: src_b = 32'd4;
    endcase
  end

  // SUB shares the adder: SrcA + ~SrcB + 1, so carry out means no borrow.
  always_comb begin
    is_sub     = (alu_ctrl_e'(bus.ALUControl) == AluSub);
    b_op       = is_sub ? ~src_b : src_b;
    sum        = {1'b0, src_a} + {1'b0, b_op} + {32'd0, is_sub};
    alu_result = sum[31:0];
    carry      = sum[32];
    ovf        = (src_a[31] == b_op[31]) && (sum[31] != src_a[31]);
    unique case (alu_ctrl_e'(bus.ALUControl))
      AluAnd: begin
        alu_result = src_a & src_b;
        carry      = 1'b0;
        ovf        = 1'b0;
      end
      AluOrr: begin
        alu_result = src_a | src_b;
        carry      = 1'b0;
        ovf        = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    result = alu_out_q;
    case (result_src_e'(bus.ResultSrc))
      ResData:      result = data_q;
      ResAluResult: result = alu_result;
      default:      result = alu_out_q;
    endcase
  end

  always_comb begin
    bus.ALUFlags         = '0;
    bus.ALUFlags[FLAG_N] = alu_result[31];
    bus.ALUFlags[FLAG_Z] = (alu_result == 32'd0);
    bus.ALUFlags[FLAG_C] = carry;
    bus.ALUFlags[FLAG_V] = ovf;
  end

  assign bus.Adr       = bus.AdrSrc ? result : pc_q;
  assign bus.WriteData = b_q;
  assign bus.MemWE     = bus.MemWrite;
  assign bus.Instr     = ir_q;

endmodule

// File: tb/tb_arm_mc_datapath.sv
// Scoreboard bench for arm_mc_datapath: expectations are queued as stimulus is
// driven and compared against bus outputs at the next sample point.
module tb_arm_mc_datapath;

  localparam int ObsInstr = 0;
  localparam int ObsAdr   = 1;
  localparam int ObsFlags = 2;
  localparam int ObsWdata = 3;
  localparam int ObsMemWe = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_entry_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;
  sb_entry_t sb[$];

  arm_mc_datapath_if bus ();

`ifdef ARM_MC_DATAPATH_DBG_PORT_EN
  logic [3:0]  dbg_ra = 4'd0;
  logic [31:0] dbg_rd;
`endif

  arm_mc_datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ARM_MC_DATAPATH_DBG_PORT_EN
    ,
    .DbgRA (dbg_ra),
    .DbgRD (dbg_rd)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      ObsInstr: return bus.Instr;
      ObsAdr:   return bus.Adr;
      ObsFlags: return {28'd0, bus.ALUFlags};
      ObsWdata: return bus.WriteData;
      default:  return {31'd0, bus.MemWE};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    sb.push_back('{tag: tag, sel: sel, exp: exp});
  endtask

  task automatic drain();
    sb_entry_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl_idle();
    bus.PCWrite    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.RegSrc     = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.ImmSrc     = 2'b00;
    bus.ALUControl = 2'b00;
  endtask

  task automatic load_ir(input logic [31:0] word);
    ctrl_idle();
    bus.ReadData = word;
    bus.IRWrite  = 1'b1;
    step();
  endtask

  // Rd = val through the load path: IR selects Rd, Data captures val, write back.
  task automatic write_reg(input logic [3:0] rd, input logic [31:0] val);
    load_ir({16'd0, rd, 12'd0});
    ctrl_idle();
    bus.ReadData = val;
    step();
    ctrl_idle();
    bus.ResultSrc = 2'b01;
    bus.RegWrite  = 1'b1;
    step();
  endtask

  task automatic alu_check(input string tag, input logic [1:0] op,
                           input logic [3:0] flags, input logic [31:0] res);
    ctrl_idle();
    bus.ALUControl = op;
    bus.ResultSrc  = 2'b10;
    bus.AdrSrc     = 1'b1;
    #1;
    push({tag, "_flags"}, ObsFlags, {28'd0, flags});
    push({tag, "_res"}, ObsAdr, res);
    drain();
  endtask

  initial begin
    reset = 1'b1;
    bus.ReadData = 32'd0;
    ctrl_idle();
    #10;
    push("rst_instr", ObsInstr, 32'd0);
    push("rst_adr", ObsAdr, 32'd0);
    push("rst_wdata", ObsWdata, 32'd0);
    push("rst_memwe", ObsMemWe, 32'd0);
    drain();
    #12;
    reset = 1'b0;

    // Fetch
    bus.ReadData  = 32'hE280_1005;
    bus.IRWrite   = 1'b1;
    bus.PCWrite   = 1'b1;
    bus.ALUSrcA   = 2'b10;
    bus.ALUSrcB   = 2'b10;
    bus.ResultSrc = 2'b10;
    #1;
    push("fetch_adr0", ObsAdr, 32'd0);
    push("fetch_flags", ObsFlags, 32'd0);
    drain();
    push("fetch_instr", ObsInstr, 32'hE280_1005);
    push("fetch_adr4", ObsAdr, 32'd4);
    step();
    drain();

    // ADD R1, R0, #5
    ctrl_idle();
    step();
    ctrl_idle();
    bus.ALUSrcB = 2'b01;
    #1;
    push("add_flags", ObsFlags, 32'd0);
    drain();
    step();
    ctrl_idle();
    bus.AdrSrc   = 1'b1;
    bus.RegWrite = 1'b1;
    #1;
    push("add_aluout", ObsAdr, 32'd5);
    drain();
    step();
    ctrl_idle();
    bus.RegSrc = 2'b10;
    step();
    push("add_r1", ObsWdata, 32'd5);
    drain();

    // SUB: R1 - R2
    write_reg(4'd2, 32'd5);
    load_ir(32'hE051_3002);
    ctrl_idle();
    step();
    alu_check("sub_eq", 2'b01, 4'b0110, 32'd0);
    write_reg(4'd2, 32'd6);
    load_ir(32'hE051_3002);
    ctrl_idle();
    step();
    alu_check("sub_neg", 2'b01, 4'b1000, 32'hFFFF_FFFF);

    // AND / ORR
    write_reg(4'd1, 32'hF0);
    write_reg(4'd2, 32'h3C);
    load_ir(32'hE051_3002);
    ctrl_idle();
    step();
    alu_check("and", 2'b10, 4'b0000, 32'h30);
    alu_check("orr", 2'b11, 4'b0000, 32'hFC);

    // LDR R4, [R0, #0x20] then STR R4
    load_ir(32'hE590_4020);
    ctrl_idle();
    step();
    ctrl_idle();
    bus.ALUSrcB = 2'b01;
    bus.ImmSrc  = 2'b01;
    step();
    ctrl_idle();
    bus.AdrSrc   = 1'b1;
    bus.ReadData = 32'hDEAD_BEEF;
    #1;
    push("ldr_adr", ObsAdr, 32'h20);
    drain();
    step();
    ctrl_idle();
    bus.ResultSrc = 2'b01;
    bus.RegWrite  = 1'b1;
    step();
    ctrl_idle();
    bus.RegSrc = 2'b10;
    step();
    push("ldr_r4", ObsWdata, 32'hDEAD_BEEF);
    drain();
    bus.MemWrite = 1'b1;
    #1;
    push("str_memwe", ObsMemWe, 32'd1);
    push("str_wdata", ObsWdata, 32'hDEAD_BEEF);
    drain();
    step();
    ctrl_idle();
    #1;
    push("memwe_off", ObsMemWe, 32'd0);
    drain();

    // Branch: fetch at PC=4 leaves PC=8
    ctrl_idle();
    bus.ReadData  = 32'hEAFF_FFFE;
    bus.IRWrite   = 1'b1;
    bus.PCWrite   = 1'b1;
    bus.ALUSrcA   = 2'b10;
    bus.ALUSrcB   = 2'b10;
    bus.ResultSrc = 2'b10;
    step();
    push("b_instr", ObsInstr, 32'hEAFF_FFFE);
    push("b_pc8", ObsAdr, 32'd8);
    drain();
    // A <- R15 (= Result = PC+4)
    ctrl_idle();
    bus.ALUSrcA   = 2'b10;
    bus.ALUSrcB   = 2'b10;
    bus.ResultSrc = 2'b10;
    bus.RegSrc    = 2'b01;
    step();
    ctrl_idle();
    bus.ALUSrcB   = 2'b01;
    bus.ImmSrc    = 2'b11;
    bus.ResultSrc = 2'b10;
    bus.AdrSrc    = 1'b1;
    #1;
    push("r15_read", ObsAdr, 32'd12);
    drain();
    step();
    ctrl_idle();
    bus.ALUSrcA = 2'b01;
    bus.ALUSrcB = 2'b10;
    step();
    // ALUOut = 16 = PC+8; target = 16 + (-8)
    ctrl_idle();
    bus.ALUSrcA   = 2'b01;
    bus.ALUSrcB   = 2'b01;
    bus.ImmSrc    = 2'b10;
    bus.ResultSrc = 2'b10;
    bus.AdrSrc    = 1'b1;
    bus.PCWrite   = 1'b1;
    #1;
    push("b_flags", ObsFlags, 32'b0010);
    push("b_target", ObsAdr, 32'd8);
    drain();
    step();
    ctrl_idle();
    #1;
    push("b_taken_pc", ObsAdr, 32'd8);
    drain();
    bus.ALUSrcA   = 2'b10;
    bus.ALUSrcB   = 2'b10;
    bus.ResultSrc = 2'b10;
    step();
    push("b_not_taken_pc", ObsAdr, 32'd8);
    drain();

    // Reset in the middle of a taken branch
    ctrl_idle();
    bus.ALUSrcA   = 2'b01;
    bus.ALUSrcB   = 2'b01;
    bus.ImmSrc    = 2'b10;
    bus.ResultSrc = 2'b10;
    bus.PCWrite   = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    push("midrst_adr", ObsAdr, 32'd0);
    push("midrst_instr", ObsInstr, 32'd0);
    push("midrst_wdata", ObsWdata, 32'd0);
    drain();
    step();
    reset = 1'b0;
    ctrl_idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/arm_mc_datapath.md
Name: arm_mc_datapath

Overview:
- Multicycle ARM datapath: the consuming end of the controller interface. Takes the controller's control signals, returns Instr[31:0] and ALUFlags[3:0].
- Holds PC, IR, Data, A, B and ALUOut registers plus a 15-entry register file. Drives the unified instruction/data memory port.
- Supports ADD, SUB, AND, ORR, LDR, STR and B with unshifted immediate or register operands.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- PCWrite  in  1  PC load enable.
- MemWrite  in  1  passed through to memory.
- RegWrite  in  1  register file write enable.
- IRWrite  in  1  IR load enable.
- AdrSrc  in  1  memory address select: 0 = PC, 1 = Result.
- RegSrc  in  2  bit0 = 1 makes RA1 = 15; bit1 = 1 makes RA2 = Instr[15:12], otherwise Instr[3:0].
- ALUSrcA  in  2  00 = A, 01 = ALUOut, 10 = PC, 11 = A.
- ALUSrcB  in  2  00 = B, 01 = ExtImm, 10 = 32'd4, 11 = 32'd4.
- ResultSrc  in  2  00 = ALUOut, 01 = Data, 10 = ALUResult (combinational), 11 = ALUOut.
- ImmSrc  in  2  extension mode, see Behaviour.
- ALUControl  in  2  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
- ReadData  in  32  memory read data.
- Adr  out  32  memory address.
- WriteData  out  32  equals B register.
- MemWE  out  1  equals MemWrite.
- Instr  out  32  IR contents.
- ALUFlags  out  4  {N,Z,C,V} of current ALU result, combinational.

Behaviour:
- Reset (async, on assertion) sets PC = RESET_PC and clears IR, Data, A, B, ALUOut and R0–R14 to 0.
  - Consequences: Instr = 0, Adr = RESET_PC, WriteData = 0.
  - Reset mid-instruction discards all in-flight state. The first post-reset edge behaves as a Fetch.
- PC loads Result when PCWrite = 1. IR loads ReadData when IRWrite = 1.
- Data, A, B and ALUOut load unconditionally every cycle: Data ← ReadData, A ← RD1, B ← RD2, ALUOut ← ALUResult. One-cycle latency each.
- Register file:
  - Two combinational read ports, one synchronous write port.
  - Write address A3 = Instr[15:12], write data = Result.
  - Reading index 15 returns Result, not storage. The R15 = PC+8 convention relies on this.
  - A write to index 15 is ignored; PC writes go only through PCWrite.
  - Read and write of the same index in one cycle: the read returns the old value.
- ImmSrc:
  - 00: zero-extend Instr[7:0].
  - 01: zero-extend Instr[11:0].
  - 10: sign-extend Instr[23:0], then shift left 2.
  - 11: 0.
- ALU, all arithmetic mod 2^32:
  - N = result[31]; Z = (result == 0).
  - ADD: C = carry out of bit 31; V = signed overflow.
  - SUB computes SrcA + ~SrcB + 1. C = 1 means no borrow; V = signed overflow.
  - AND/ORR: C = 0, V = 0.
- Adr = AdrSrc ? Result : PC. Control inputs outside the listed encodings follow the table entries above; no X propagation.

Optional Feature:
- Macro: ARM_MC_DATAPATH_DBG_PORT_EN.
- When defined, adds ports DbgRA (in, 4) and DbgRD (out, 32): a third combinational read port on the register file. Index 15 returns PC.
- When undefined, those ports do not exist and functional behaviour is identical.

Decomposition:
- Package arm_mc_pkg holds:
  - enums for ALUSrcA, ALUSrcB, ResultSrc, ImmSrc and ALUControl encodings;
  - localparam PC_IDX = 4'd15;
  - flag bit positions N = 3, Z = 2, C = 1, V = 0.
- One sub-module, arm_mc_regfile: R0–R14, async reset, R15 input, optional debug port.
- Extender, ALU and muxes stay inline.

Test Plan:
- Fetch after reset: hold reset 22 ns. ReadData = 32'hE2801005, IRWrite = 1, PCWrite = 1, ALUSrcA = 10, ALUSrcB = 10, ResultSrc = 10. Next edge: Instr = 32'hE2801005, PC = 4, Adr = 4.
- ADD immediate (R1 = R0 + 5): RegSrc = 00, ALUSrcA = 00, ALUSrcB = 01, ImmSrc = 00, ALUControl = 00 → ALUOut = 5. Then ResultSrc = 00 with RegWrite = 1 → R1 = 5.
- SUB: R1 = 5, R2 = 5, ALUControl = 01, ALUSrcB = 00 → result 0, ALUFlags = 4'b0110. With R2 = 6: result 32'hFFFFFFFF, ALUFlags = 4'b1000.
- AND/ORR: A = 32'hF0, B = 32'h3C. AND → 32'h30, flags 4'b0000. ORR → 32'hFC.
- LDR then STR:
  - ALUOut = 32'h20 with AdrSrc = 1 and ResultSrc = 00 → Adr = 32'h20.
  - ReadData = 32'hDEADBEEF, then ResultSrc = 01 with RegWrite → Rd = 32'hDEADBEEF.
  - STR with MemWrite = 1 → MemWE = 1 and WriteData = B.
- Branch plus mid-op reset:
  - Instr[23:0] = 24'hFFFFFE, ImmSrc = 10 → ExtImm = 32'hFFFFFFF8.
  - PC = 8: taken branch gives PC = 8 + 8 − 8 = 8. Not taken (PCWrite = 0) leaves PC unchanged.
  - Asserting reset mid-branch immediately sets PC = RESET_PC and Instr = 0.
